// File: rtl/carry_chain_pkg.sv
// Shared constants and helpers for the CARRY4-cascade minitests.
// Slice geometry and carry-in source encodings live here so every user agrees on them.
package carry_chain_pkg;

   localparam int SLICE_W    = 4;

   // Carry-in source for slice 0 of the cascade.
   localparam int CIN_CYINIT = 0;
   localparam int CIN_CI     = 1;

   function automatic int nslices(input int width);
      return (width + SLICE_W - 1) / SLICE_W;
   endfunction

endpackage

// File: rtl/carry_chain_accum_if.sv
// Operand/result bundle for carry_chain_accum.
// The master drives operands and controls; the slave returns the registered result.
interface carry_chain_accum_if #(
   parameter int WIDTH = 16
);

   // Handshake: there is no back-pressure. The slave samples load/en/sub/cin/din on
   // every rising clk. valid is high for exactly one cycle after an edge that saw
   // load or en, and q/co/ovf are stable (held) whenever valid is low.
   logic             load;
   logic             en;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] q;
   logic             co;
   logic             ovf;
   logic             valid;

   modport master (
      output load, en, sub, cin, din,
      input  q, co, ovf, valid
   );

   modport slave (
      input  load, en, sub, cin, din,
      output q, co, ovf, valid
   );

endinterface

// File: rtl/carry_chain_adder.sv
// Combinational WIDTH-bit adder built as a cascade of CARRY4 slices, with the slice-0
// carry-in routed either through CYINIT or through a passthrough CARRY4 onto CI.
module carry_chain_adder
   import carry_chain_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CIN_MODE = CIN_CYINIT
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NS = nslices(WIDTH);

   if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("carry_chain_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   if (CIN_MODE != CIN_CYINIT && CIN_MODE != CIN_CI) begin : g_bad_mode
      $error("carry_chain_adder: CIN_MODE must be 0 or 1");
   end

   logic [NS-1:0]   co3;
   logic [3*NS-1:0] unused_co;
   logic            slice0_ci;
   logic            slice0_cyinit;

   if (CIN_MODE == CIN_CI) begin : g_cin_ci
      logic [3:0] unused_pt_o;
      logic [2:0] unused_pt_co;
      logic       pt_co3;

      // With S=0 every bit generates DI, so CO[3] reproduces DI[3] = cin.
      carry_chain_carry4 u_passthru (
         .ci     (1'b1),
         .cyinit (1'b1),
         .di     ({cin, 3'b000}),
         .s      (4'b0000),
         .o      (unused_pt_o),
         .co     ({pt_co3, unused_pt_co})
      );

      assign slice0_ci     = pt_co3;
      assign slice0_cyinit = 1'b0;
   end else begin : g_cin_cyinit
      assign slice0_ci     = 1'b0;
      assign slice0_cyinit = cin;
   end

   for (genvar k = 0; k < NS; k++) begin : g_slice
      logic ci_k;
      logic cyinit_k;

      if (k == 0) begin : g_first
         assign ci_k     = slice0_ci;
         assign cyinit_k = slice0_cyinit;
      end else begin : g_next
         assign ci_k     = co3[k-1];
         assign cyinit_k = 1'b0;
      end

      carry_chain_carry4 u_carry4 (
         .ci     (ci_k),
         .cyinit (cyinit_k),
         .di     (a[SLICE_W*k +: SLICE_W]),
         .s      (a[SLICE_W*k +: SLICE_W] ^ b[SLICE_W*k +: SLICE_W]),
         .o      (sum[SLICE_W*k +: SLICE_W]),
         .co     ({co3[k], unused_co[3*k +: 3]})
      );
   end

   assign cout = co3[NS-1];

endmodule

// File: rtl/carry_chain_carry4.sv
// Behavioural model of one 4-bit CARRY4 slice: carry into bit 0 is CI | CYINIT,
// each bit propagates when S is high and generates DI otherwise.
module carry_chain_carry4 (
   input  logic       ci,
   input  logic       cyinit,
   input  logic [3:0] di,
   input  logic [3:0] s,
   output logic [3:0] o,
   output logic [3:0] co
);

   logic [4:0] c;

   always_comb begin
      c    = '0;
      c[0] = ci | cyinit;
      for (int i = 0; i < 4; i++) begin
         c[i+1] = s[i] ? c[i] : di[i];
      end
   end

   assign o  = s ^ c[3:0];
   assign co = c[4:1];

endmodule

// File: rtl/carry_chain_accum.sv
// Registered accumulator around carry_chain_adder: load, add/subtract with carry-in,
// registered top carry, sticky signed overflow and a one-cycle update pulse.
module carry_chain_accum
   import carry_chain_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CIN_MODE = CIN_CYINIT
) (
   input logic                clk,
   input logic                rst_n,
   carry_chain_accum_if.slave bus
);

   if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("carry_chain_accum: WIDTH must be a multiple of 4 and at least 4");
   end

   logic [WIDTH-1:0] q_q, q_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             v;

   // Subtraction is q + ~din + cin; cin=1 completes the two's complement.
   assign b = bus.din ^ {WIDTH{bus.sub}};

   carry_chain_adder #(
      .WIDTH    (WIDTH),
      .CIN_MODE (CIN_MODE)
   ) u_adder (
      .a    (q_q),
      .b    (b),
      .cin  (bus.cin),
      .sum  (sum),
      .cout (cout)
   );

   // Signed overflow: both addends share a sign and the result's sign differs.
   assign v = (q_q[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != q_q[WIDTH-1]);

   always_comb begin
      q_d     = q_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      if (bus.load) begin
         q_d     = bus.din;
         co_d    = 1'b0;
         ovf_d   = 1'b0;
         valid_d = 1'b1;
      end else if (bus.en) begin
         q_d     = sum;
         co_d    = cout;
         ovf_d   = ovf_q | v;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign bus.q     = q_q;
   assign bus.co    = co_q;
   assign bus.ovf   = ovf_q;
   assign bus.valid = valid_q;

endmodule

// File: tb/tb_carry_chain_accum.sv
// Directed bench: two 16-bit accumulators (CYINIT and CI carry-in routing) driven in
// lockstep, plus 4-bit and 32-bit spot checks, all against hand-computed results.
module tb_carry_chain_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load, en, sub, cin;
   logic [31:0] din;

   int vectors     = 0;
   int miscompares = 0;

   carry_chain_accum_if #(.WIDTH(16)) bus16_0 ();
   carry_chain_accum_if #(.WIDTH(16)) bus16_1 ();
   carry_chain_accum_if #(.WIDTH(4))  bus4 ();
   carry_chain_accum_if #(.WIDTH(32)) bus32 ();

   assign {bus16_0.load, bus16_0.en, bus16_0.sub, bus16_0.cin} = {load, en, sub, cin};
   assign {bus16_1.load, bus16_1.en, bus16_1.sub, bus16_1.cin} = {load, en, sub, cin};
   assign {bus4.load, bus4.en, bus4.sub, bus4.cin}             = {load, en, sub, cin};
   assign {bus32.load, bus32.en, bus32.sub, bus32.cin}         = {load, en, sub, cin};
   assign bus16_0.din = din[15:0];
   assign bus16_1.din = din[15:0];
   assign bus4.din    = din[3:0];
   assign bus32.din   = din;

   carry_chain_accum #(.WIDTH(16), .CIN_MODE(0)) dut16_0 (.clk(clk), .rst_n(rst_n), .bus(bus16_0.slave));
   carry_chain_accum #(.WIDTH(16), .CIN_MODE(1)) dut16_1 (.clk(clk), .rst_n(rst_n), .bus(bus16_1.slave));
   carry_chain_accum #(.WIDTH(4),  .CIN_MODE(0)) dut4    (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   carry_chain_accum #(.WIDTH(32), .CIN_MODE(1)) dut32   (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

   // Observed result words: {q, co, ovf, valid}.
   logic [18:0] obs16 [2];
   logic [6:0]  obs4;
   logic [34:0] obs32;
   assign obs16[0] = {bus16_0.q, bus16_0.co, bus16_0.ovf, bus16_0.valid};
   assign obs16[1] = {bus16_1.q, bus16_1.co, bus16_1.ovf, bus16_1.valid};
   assign obs4     = {bus4.q, bus4.co, bus4.ovf, bus4.valid};
   assign obs32    = {bus32.q, bus32.co, bus32.ovf, bus32.valid};

   always #5 clk = ~clk;

   task automatic apply(input logic l, input logic e, input logic s, input logic c,
                        input logic [31:0] d);
      load = l;
      en   = e;
      sub  = s;
      cin  = c;
      din  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int m = 0; m < 2; m++) begin
         vectors++;
         if (obs16[m] !== 19'h0) begin
            miscompares++;
            $display("FAIL reset16 mode%0d: got %h, expected 0", m, obs16[m]);
         end
      end
      vectors++;
      if (obs4 !== 7'h0) begin
         miscompares++;
         $display("FAIL reset4: got %h, expected 0", obs4);
      end
      vectors++;
      if (obs32 !== 35'h0) begin
         miscompares++;
         $display("FAIL reset32: got %h, expected 0", obs32);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h5);
      for (int m = 0; m < 2; m++) begin
         vectors++;
         if (obs16[m] !== {16'h0005, 3'b001}) begin
            miscompares++;
            $display("FAIL reset_release mode%0d: got q=%h co,ovf,valid=%b, expected q=0005 001",
                     m, obs16[m][18:3], obs16[m][2:0]);
         end
      end
   endtask

   task automatic test_cross_slice();
      logic [19:0] stim [3];
      logic [18:0] expv [3];
      stim = '{{4'b1000, 16'h00FF}, {4'b0100, 16'h0001}, {4'b0000, 16'h0000}};
      expv = '{{16'h00FF, 3'b001}, {16'h0100, 3'b001}, {16'h0100, 3'b000}};
      for (int i = 0; i < 3; i++) begin
         apply(stim[i][19], stim[i][18], stim[i][17], stim[i][16], {16'h0, stim[i][15:0]});
         for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs16[m] !== expv[i]) begin
               miscompares++;
               $display("FAIL cross_slice[%0d] mode%0d: got q=%h co,ovf,valid=%b, expected q=%h %b",
                        i, m, obs16[m][18:3], obs16[m][2:0], expv[i][18:3], expv[i][2:0]);
            end
         end
      end
   endtask

   task automatic test_cin_chain();
      logic [19:0] stim [2];
      logic [18:0] expv [2];
      stim = '{{4'b1000, 16'hFFFF}, {4'b0101, 16'h0000}};
      expv = '{{16'hFFFF, 3'b001}, {16'h0000, 3'b101}};
      for (int i = 0; i < 2; i++) begin
         apply(stim[i][19], stim[i][18], stim[i][17], stim[i][16], {16'h0, stim[i][15:0]});
         for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs16[m] !== expv[i]) begin
               miscompares++;
               $display("FAIL cin_chain[%0d] mode%0d: got q=%h co,ovf,valid=%b, expected q=%h %b",
                        i, m, obs16[m][18:3], obs16[m][2:0], expv[i][18:3], expv[i][2:0]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [19:0] stim [5];
      logic [18:0] expv [5];
      stim = '{{4'b1000, 16'h7FFF}, {4'b0100, 16'h0001}, {4'b0100, 16'h0000},
               {4'b0000, 16'h0000}, {4'b1000, 16'h0000}};
      expv = '{{16'h7FFF, 3'b001}, {16'h8000, 3'b011}, {16'h8000, 3'b011},
               {16'h8000, 3'b010}, {16'h0000, 3'b001}};
      for (int i = 0; i < 5; i++) begin
         apply(stim[i][19], stim[i][18], stim[i][17], stim[i][16], {16'h0, stim[i][15:0]});
         for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs16[m] !== expv[i]) begin
               miscompares++;
               $display("FAIL overflow[%0d] mode%0d: got q=%h co,ovf,valid=%b, expected q=%h %b",
                        i, m, obs16[m][18:3], obs16[m][2:0], expv[i][18:3], expv[i][2:0]);
            end
         end
      end
   endtask

   task automatic test_subtract();
      logic [19:0] stim [3];
      logic [18:0] expv [3];
      stim = '{{4'b1000, 16'h0005}, {4'b0111, 16'h0003}, {4'b0111, 16'h0006}};
      expv = '{{16'h0005, 3'b001}, {16'h0002, 3'b101}, {16'hFFFC, 3'b001}};
      for (int i = 0; i < 3; i++) begin
         apply(stim[i][19], stim[i][18], stim[i][17], stim[i][16], {16'h0, stim[i][15:0]});
         for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs16[m] !== expv[i]) begin
               miscompares++;
               $display("FAIL subtract[%0d] mode%0d: got q=%h co,ovf,valid=%b, expected q=%h %b",
                        i, m, obs16[m][18:3], obs16[m][2:0], expv[i][18:3], expv[i][2:0]);
            end
         end
      end
   endtask

   task automatic test_priority_hold();
      logic [19:0] stim [6];
      logic [18:0] expv [6];
      stim = '{{4'b1000, 16'hFFFF}, {4'b0101, 16'h0000}, {4'b1100, 16'h1234},
               {4'b0000, 16'hFFFF}, {4'b0000, 16'hFFFF}, {4'b0000, 16'hFFFF}};
      expv = '{{16'hFFFF, 3'b001}, {16'h0000, 3'b101}, {16'h1234, 3'b001},
               {16'h1234, 3'b000}, {16'h1234, 3'b000}, {16'h1234, 3'b000}};
      for (int i = 0; i < 6; i++) begin
         apply(stim[i][19], stim[i][18], stim[i][17], stim[i][16], {16'h0, stim[i][15:0]});
         for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs16[m] !== expv[i]) begin
               miscompares++;
               $display("FAIL priority_hold[%0d] mode%0d: got q=%h co,ovf,valid=%b, expected q=%h %b",
                        i, m, obs16[m][18:3], obs16[m][2:0], expv[i][18:3], expv[i][2:0]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] stim [5];
      logic [18:0] expv [5];
      stim = '{{4'b1000, 16'h0000}, {4'b0100, 16'h1111}, {4'b0100, 16'h1111},
               {4'b0100, 16'h1111}, {4'b0101, 16'h00FF}};
      expv = '{{16'h0000, 3'b001}, {16'h1111, 3'b001}, {16'h2222, 3'b001},
               {16'h3333, 3'b001}, {16'h3433, 3'b001}};
      for (int i = 0; i < 5; i++) begin
         apply(stim[i][19], stim[i][18], stim[i][17], stim[i][16], {16'h0, stim[i][15:0]});
         for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs16[m] !== expv[i]) begin
               miscompares++;
               $display("FAIL back_to_back[%0d] mode%0d: got q=%h co,ovf,valid=%b, expected q=%h %b",
                        i, m, obs16[m][18:3], obs16[m][2:0], expv[i][18:3], expv[i][2:0]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [18:0] expv [4];
      expv = '{{16'h0010, 3'b001}, {16'h0011, 3'b001}, {16'h0000, 3'b000}, {16'h0001, 3'b001}};
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
            1: apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
            2: begin
               #2 rst_n = 1'b0;
               #1;
            end
            default: begin
               #1 rst_n = 1'b1;
               apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
            end
         endcase
         for (int m = 0; m < 2; m++) begin
            vectors++;
            if (obs16[m] !== expv[i]) begin
               miscompares++;
               $display("FAIL async_reset[%0d] mode%0d: got q=%h co,ovf,valid=%b, expected q=%h %b",
                        i, m, obs16[m][18:3], obs16[m][2:0], expv[i][18:3], expv[i][2:0]);
            end
         end
      end
   endtask

   task automatic test_widths();
      logic [35:0] stim [6];
      logic [6:0]  exp4 [6];
      logic [34:0] exp32 [6];
      stim  = '{{4'b1000, 32'hFFFF_FFFF}, {4'b0101, 32'h0}, {4'b1000, 32'h7FFF_FFFF},
                {4'b0100, 32'h1}, {4'b1000, 32'h7}, {4'b0100, 32'h1}};
      exp4  = '{{4'hF, 3'b001}, {4'h0, 3'b101}, {4'hF, 3'b001},
                {4'h0, 3'b101}, {4'h7, 3'b001}, {4'h8, 3'b011}};
      exp32 = '{{32'hFFFF_FFFF, 3'b001}, {32'h0, 3'b101}, {32'h7FFF_FFFF, 3'b001},
                {32'h8000_0000, 3'b011}, {32'h7, 3'b001}, {32'h8, 3'b001}};
      for (int i = 0; i < 6; i++) begin
         apply(stim[i][35], stim[i][34], stim[i][33], stim[i][32], stim[i][31:0]);
         vectors++;
         if (obs4 !== exp4[i]) begin
            miscompares++;
            $display("FAIL width4[%0d]: got q=%h co,ovf,valid=%b, expected q=%h %b",
                     i, obs4[6:3], obs4[2:0], exp4[i][6:3], exp4[i][2:0]);
         end
         vectors++;
         if (obs32 !== exp32[i]) begin
            miscompares++;
            $display("FAIL width32[%0d]: got q=%h co,ovf,valid=%b, expected q=%h %b",
                     i, obs32[34:3], obs32[2:0], exp32[i][34:3], exp32[i][2:0]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      load  = 1'b0;
      en    = 1'b0;
      sub   = 1'b0;
      cin   = 1'b0;
      din   = 32'h0;
      #12;
      test_reset();
      test_cross_slice();
      test_cin_chain();
      test_overflow();
      test_subtract();
      test_priority_hold();
      test_back_to_back();
      test_async_reset();
      test_widths();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
